// File: rtl/prog_mem_loader.sv
// prog_mem_loader: streams a boot image into single-port BSRAM, then hands the BSRAM to the CPU as its instruction fetch port
module prog_mem_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int IMAGE_LEN = 3,
  parameter int BASE_ADDR = 0,
  parameter int AUTO_BOOT = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  input  logic [ADDR_W-1:0] cpu_adr,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_hold,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  if (IMAGE_LEN < 1 || IMAGE_LEN > (1 << ADDR_W)) begin : g_len_chk
    $error("prog_mem_loader: IMAGE_LEN out of range");
  end
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(IMAGE_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  state_t state;
  logic [ADDR_W:0] idx;
  logic [ADDR_W-1:0] load_addr;
  logic start;
  always_comb begin
    start = (state == IDLE && (AUTO_BOOT != 0 || load_req)) || (state == RUN && load_req);
    src_ready = state == LOAD;
    mem_ad = state == RUN ? cpu_adr : load_addr;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      cpu_hold <= 1'b1;
      done <= 1'b0;
      checksum <= '0;
      mem_ce <= 1'b0;
      mem_wre <= 1'b0;
      mem_din <= '0;
      load_addr <= BASE;
      cpu_instr <= NOP_WORD;
    end else begin
      mem_wre <= 1'b0;
      // the instruction drops to NOP on the same edge that re-enters LOAD
      cpu_instr <= state == RUN && !start ? mem_dout : NOP_WORD;
      if (start) begin
        state <= LOAD;
        idx <= '0;
        checksum <= '0;
        done <= 1'b0;
        cpu_hold <= 1'b1;
      end else if (state == LOAD && src_valid) begin
        mem_din <= src_data;
        mem_wre <= 1'b1;
        mem_ce <= 1'b1;
        load_addr <= BASE + idx[ADDR_W-1:0];
        checksum <= checksum ^ src_data;
        idx <= idx + (ADDR_W+1)'(1);
        if (idx == LAST) state <= FLUSH;
      end else if (state == FLUSH) begin
        state <= RUN;
        cpu_hold <= 1'b0;
        done <= 1'b1;
        mem_ce <= 1'b1;
      end
    end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: two loaders (base 0 and base 2046) fed one stream, checked by write/fetch scoreboards
module tb_prog_mem_loader;
  typedef struct {logic [10:0] a; logic [15:0] d;} wr_t;
  typedef struct {int due; logic [15:0] v;} exp_t;
  logic clk = 1'b0;
  logic reset, load_req, src_valid;
  logic [15:0] src_data;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int widx;
  logic [15:0] xexp;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int B = k == 0 ? 0 : 2046;
    logic src_ready, cpu_hold, done, mem_ce, mem_wre;
    logic [15:0] cpu_instr, checksum, mem_din, mem_dout;
    logic [10:0] mem_ad, cpu_adr;
    logic [15:0] bram [2048];
    logic [15:0] model [2048];
    wr_t qw[$];
    exp_t qi[$];
    wr_t w;
    exp_t e;
    prog_mem_loader #(.BASE_ADDR(B)) dut (
      .clk(clk), .reset(reset), .load_req(load_req), .src_valid(src_valid),
      .src_data(src_data), .src_ready(src_ready), .cpu_adr(cpu_adr),
      .cpu_instr(cpu_instr), .cpu_hold(cpu_hold), .done(done), .checksum(checksum),
      .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_ad(mem_ad), .mem_din(mem_din),
      .mem_dout(mem_dout)
    );
    always @(posedge clk)
      if (mem_ce) begin
        if (mem_wre) bram[mem_ad] <= mem_din;
        mem_dout <= bram[mem_ad];
      end
    always @(negedge clk)
      if (!reset) begin
        if (mem_wre) begin
          if (qw.size() == 0) chk($sformatf("wr%0d_unexpected ad=%h", k, mem_ad), 32'(mem_din), 32'hffffffff);
          else begin
            w = qw.pop_front();
            chk($sformatf("wr%0d_addr", k), 32'(mem_ad), 32'(w.a));
            chk($sformatf("wr%0d_data", k), 32'(mem_din), 32'(w.d));
            chk($sformatf("wr%0d_ce", k), 32'(mem_ce), 32'd1);
          end
        end
        if (qi.size() > 0 && qi[0].due <= cyc) begin
          e = qi.pop_front();
          chk($sformatf("instr%0d_due%0d", k, e.due), 32'(cpu_instr), 32'(e.v));
        end
        if (cpu_hold) chk($sformatf("hold_nop%0d", k), 32'(cpu_instr), 32'd0);
      end
    task automatic push_word(input int i, input logic [15:0] d);
      wr_t x;
      x.a = 11'((B + i) % 2048);
      x.d = d;
      qw.push_back(x);
      model[x.a] = d;
    endtask
    task automatic read(input int off);
      exp_t x;
      cpu_adr = 11'((B + off) % 2048);
      x.due = cyc + 2;
      x.v = model[cpu_adr];
      qi.push_back(x);
    endtask
    task automatic chk_rst();
      chk($sformatf("rst%0d_src_ready", k), 32'(src_ready), 32'd0);
      chk($sformatf("rst%0d_cpu_hold", k), 32'(cpu_hold), 32'd1);
      chk($sformatf("rst%0d_done", k), 32'(done), 32'd0);
      chk($sformatf("rst%0d_checksum", k), 32'(checksum), 32'd0);
      chk($sformatf("rst%0d_mem_ce", k), 32'(mem_ce), 32'd0);
      chk($sformatf("rst%0d_mem_wre", k), 32'(mem_wre), 32'd0);
      chk($sformatf("rst%0d_mem_din", k), 32'(mem_din), 32'd0);
      chk($sformatf("rst%0d_mem_ad", k), 32'(mem_ad), 32'(B));
      chk($sformatf("rst%0d_cpu_instr", k), 32'(cpu_instr), 32'd0);
    endtask
    task automatic chk_run();
      chk($sformatf("run%0d_done", k), 32'(done), 32'd1);
      chk($sformatf("run%0d_hold", k), 32'(cpu_hold), 32'd0);
      chk($sformatf("run%0d_checksum", k), 32'(checksum), 32'(xexp));
    endtask
    task automatic chk_reload();
      chk($sformatf("reload%0d_hold", k), 32'(cpu_hold), 32'd1);
      chk($sformatf("reload%0d_nop", k), 32'(cpu_instr), 32'd0);
      chk($sformatf("reload%0d_done", k), 32'(done), 32'd0);
      chk($sformatf("reload%0d_checksum", k), 32'(checksum), 32'd0);
    endtask
  end

  task automatic new_load();
    widx = 0;
    xexp = '0;
  endtask

  task automatic send(input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    src_valid = 1'b1;
    src_data = d;
    while (!g[0].src_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("src_ready_wait", 32'(n < 50), 32'd1);
    g[0].push_word(widx, d);
    g[1].push_word(widx, d);
    widx++;
    xexp ^= d;
    @(posedge clk);
  endtask

  task automatic stall(input int n, input logic lr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      src_valid = 1'b0;
      src_data = 16'($urandom);
      load_req = lr && i == 0;
    end
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    src_valid = 1'b0;
    while (!(g[0].done && g[1].done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", 32'(n < 100), 32'd1);
    g[0].chk_run();
    g[1].chk_run();
  endtask

  task automatic run_reads(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g[0].read(i == 0 ? first : int'($urandom_range(0, 2)));
      g[1].read(i == 0 ? first : int'($urandom_range(0, 2)));
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    load_req = 1'b0;
    src_valid = 1'b0;
    src_data = '0;
    g[0].cpu_adr = '0;
    g[1].cpu_adr = '0;
    repeat (3) @(negedge clk);
    g[0].chk_rst();
    g[1].chk_rst();
    new_load();
    reset = 1'b0;
    fork
      begin
        send(16'h00A1);
        send(16'h0078);
        send(16'h0091);
        @(negedge clk);
        src_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("boot_done_early0", 32'(g[0].done), 32'd0);
        chk("boot_done_early1", 32'(g[1].done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("boot_done_at5", 32'(g[0].done), 32'd1);
        chk("boot_hold_at5", 32'(g[0].cpu_hold), 32'd0);
        chk("boot_done_at5_wrap", 32'(g[1].done), 32'd1);
      end
    join
    g[0].chk_run();
    g[1].chk_run();
    run_reads(10, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    new_load();
    reset = 1'b0;
    send(16'h00A1);
    stall(4, 1'b0);
    send(16'h0078);
    send(16'h0091);
    wait_done();
    run_reads(8, 2);
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      load_req = 1'b1;
      new_load();
      @(negedge clk);
      load_req = 1'b0;
      g[0].chk_reload();
      g[1].chk_reload();
      for (int i = 0; i < 3; i++) begin
        send(16'($urandom));
        if (i < 2) stall(int'($urandom_range(1, 3)), i == r % 2);
      end
      wait_done();
      run_reads(8, 0);
    end
    @(negedge clk);
    load_req = 1'b1;
    new_load();
    @(negedge clk);
    load_req = 1'b0;
    send(16'($urandom));
    @(negedge clk);
    #1;
    reset = 1'b1;
    src_valid = 1'b0;
    #1;
    g[0].chk_rst();
    g[1].chk_rst();
    repeat (2) @(negedge clk);
    new_load();
    reset = 1'b0;
    send(16'h1234);
    send(16'h0F0F);
    send(16'hBEEF);
    wait_done();
    run_reads(8, 0);
    chk("wr_queue_empty0", 32'(g[0].qw.size()), 32'd0);
    chk("wr_queue_empty1", 32'(g[1].qw.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
